// File: rtl/muldiv_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | muldiv_sequencer_pkg                                                       |
// | Function codes and state encoding shared by the HI/LO multiply/divide unit |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package muldiv_sequencer_pkg;

    localparam int unsigned c_XLEN = 32;

    typedef logic [5:0] func_t;

    localparam func_t FUNC_MTHI  = 6'h11;
    localparam func_t FUNC_MTLO  = 6'h13;
    localparam func_t FUNC_MULT  = 6'h18;
    localparam func_t FUNC_MULTU = 6'h19;
    localparam func_t FUNC_DIV   = 6'h1A;
    localparam func_t FUNC_DIVU  = 6'h1B;
    localparam func_t FUNC_ADD   = 6'h20;

    typedef enum logic [1:0] {
        MD_IDLE    = 2'd0,
        MD_DIV_RUN = 2'd1,
        MD_DIV_FIX = 2'd2
    } muldiv_state_t;

    function automatic logic is_div_funct(input func_t f);
        return (f == FUNC_DIV) || (f == FUNC_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | muldiv_sequencer_if                                                        |
// | Execute-stage request/result bundle between the core and the HI/LO unit    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface muldiv_sequencer_if;
    import muldiv_sequencer_pkg::*;

    logic        start_i;
    func_t       funct_i;
    logic        flush_i;
    logic [31:0] rs_i;
    logic [31:0] rt_i;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stall_o;

    modport master (
        output start_i, funct_i, flush_i, rs_i, rt_i,
        input  hi_o, lo_o, stall_o
    );

    modport slave (
        input  start_i, funct_i, flush_i, rs_i, rt_i,
        output hi_o, lo_o, stall_o
    );

endinterface
`default_nettype wire

// File: rtl/muldiv_div_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | muldiv_div_step                                                            |
// | One combinational restoring-division step on a rem:quo register pair       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module muldiv_div_step (
    input  logic [31:0] i_rem,
    input  logic [31:0] i_quo,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_rem,
    output logic [31:0] o_quo
);

    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;

    // rem < divisor on entry, so the shifted value always fits in 33 bits
    assign w_rem_sh = {i_rem, i_quo[31]};
    assign w_diff   = w_rem_sh - {1'b0, i_divisor};

    always_comb begin
        o_rem = w_rem_sh[31:0];
        o_quo = {i_quo[30:0], 1'b0};
        if (!w_diff[32]) begin
            o_rem = w_diff[31:0];
            o_quo = {i_quo[30:0], 1'b1};
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | muldiv_sequencer                                                           |
// | HI/LO owner: single-cycle MULT/MULTU, iterative DIV/DIVU with stall, MTHI/LO|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int unsigned DIV_STEPS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    muldiv_sequencer_if.slave bus
);

    localparam int unsigned         c_RUN_CYCLES = c_XLEN / DIV_STEPS_PER_CYCLE;
    localparam int unsigned         c_CNT_W      = $clog2(c_RUN_CYCLES) + 1;
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST   = c_CNT_W'(c_RUN_CYCLES - 1);

    muldiv_state_t      r_state;
    muldiv_state_t      w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_rem;
    logic [31:0]        r_quo;
    logic [31:0]        r_divisor;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div_zero;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic        w_accept;
    logic        w_accept_div;
    logic        w_signed_div;
    logic        w_rs_neg;
    logic        w_rt_neg;
    logic [31:0] w_rs_abs;
    logic [31:0] w_rt_abs;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;

    logic [31:0] w_rem_chain [DIV_STEPS_PER_CYCLE+1];
    logic [31:0] w_quo_chain [DIV_STEPS_PER_CYCLE+1];

    assign w_accept     = bus.start_i & ~bus.flush_i & (r_state == MD_IDLE);
    assign w_accept_div = w_accept & is_div_funct(bus.funct_i);

    assign w_signed_div = (bus.funct_i == FUNC_DIV);
    assign w_rs_neg     = w_signed_div & bus.rs_i[31];
    assign w_rt_neg     = w_signed_div & bus.rt_i[31];
    assign w_rs_abs     = w_rs_neg ? (~bus.rs_i + 32'd1) : bus.rs_i;
    assign w_rt_abs     = w_rt_neg ? (~bus.rt_i + 32'd1) : bus.rt_i;

    assign w_prod_s = $signed({{32{bus.rs_i[31]}}, bus.rs_i}) * $signed({{32{bus.rt_i[31]}}, bus.rt_i});
    assign w_prod_u = {32'd0, bus.rs_i} * {32'd0, bus.rt_i};

    assign w_rem_chain[0] = r_rem;
    assign w_quo_chain[0] = r_quo;

    for (genvar g = 0; g < DIV_STEPS_PER_CYCLE; g++) begin : g_step
        muldiv_div_step u_step (
            .i_rem     (w_rem_chain[g]),
            .i_quo     (w_quo_chain[g]),
            .i_divisor (r_divisor),
            .o_rem     (w_rem_chain[g+1]),
            .o_quo     (w_quo_chain[g+1])
        );
    end

    // A zero divisor leaves rem = |rs| with neg_r = sign(rs), so HI comes back as raw rs
    assign w_q_fix = r_div_zero ? 32'hFFFF_FFFF : (r_neg_q ? (~r_quo + 32'd1) : r_quo);
    assign w_r_fix = r_neg_r ? (~r_rem + 32'd1) : r_rem;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            MD_IDLE: begin
                if (w_accept_div) w_state_nxt = MD_DIV_RUN;
            end
            MD_DIV_RUN: begin
                if (bus.flush_i)              w_state_nxt = MD_IDLE;
                else if (r_cnt == c_CNT_LAST) w_state_nxt = MD_DIV_FIX;
            end
            MD_DIV_FIX: w_state_nxt = MD_IDLE;
            default:    w_state_nxt = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= MD_IDLE;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_divisor  <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_accept_div) begin
                r_rem      <= '0;
                r_quo      <= w_rs_abs;
                r_divisor  <= w_rt_abs;
                r_neg_q    <= w_rs_neg ^ w_rt_neg;
                r_neg_r    <= w_rs_neg;
                r_div_zero <= (bus.rt_i == 32'd0);
                r_cnt      <= '0;
            end else if (r_state == MD_DIV_RUN) begin
                r_rem <= w_rem_chain[DIV_STEPS_PER_CYCLE];
                r_quo <= w_quo_chain[DIV_STEPS_PER_CYCLE];
                r_cnt <= r_cnt + c_CNT_W'(1);
            end

            if (w_accept) begin
                case (bus.funct_i)
                    FUNC_MULT:  {r_hi, r_lo} <= w_prod_s;
                    FUNC_MULTU: {r_hi, r_lo} <= w_prod_u;
                    FUNC_MTHI:  r_hi <= bus.rs_i;
                    FUNC_MTLO:  r_lo <= bus.rs_i;
                    default:    ;
                endcase
            end else if ((r_state == MD_DIV_FIX) && !bus.flush_i) begin
                r_hi <= w_r_fix;
                r_lo <= w_q_fix;
            end
        end
    end

    assign bus.stall_o = (r_state != MD_IDLE) | w_accept_div;
    assign bus.hi_o    = r_hi;
    assign bus.lo_o    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_muldiv_sequencer                                                        |
// | Drives one- and four-step-per-cycle sequencers in lockstep against a model |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    func_t       funct;
    logic        flush;
    logic [31:0] rs;
    logic [31:0] rt;

    always #5 clk = ~clk;

    muldiv_sequencer_if u_if1 ();
    muldiv_sequencer_if u_if4 ();

    assign u_if1.start_i = start;
    assign u_if1.funct_i = funct;
    assign u_if1.flush_i = flush;
    assign u_if1.rs_i    = rs;
    assign u_if1.rt_i    = rt;
    assign u_if4.start_i = start;
    assign u_if4.funct_i = funct;
    assign u_if4.flush_i = flush;
    assign u_if4.rs_i    = rs;
    assign u_if4.rt_i    = rt;

    muldiv_sequencer #(.DIV_STEPS_PER_CYCLE(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if1.slave)
    );

    muldiv_sequencer #(.DIV_STEPS_PER_CYCLE(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if4.slave)
    );

    typedef struct {
        func_t       f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];
    exp_t m;
    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic exp_t model(input func_t f, input logic [31:0] a, input logic [31:0] b, input exp_t cur);
        exp_t            r;
        int              sa;
        int              sb;
        longint          ps;
        longint unsigned pu;
        r  = cur;
        sa = a;
        sb = b;
        case (f)
            FUNC_MULT: begin
                ps = longint'(sa) * longint'(sb);
                {r.hi, r.lo} = ps;
            end
            FUNC_MULTU: begin
                pu = longint'({32'd0, a}) * longint'({32'd0, b});
                {r.hi, r.lo} = pu;
            end
            FUNC_DIV: begin
                if (b == 32'd0) begin
                    r.lo = 32'hFFFF_FFFF; r.hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r.lo = 32'h8000_0000; r.hi = 32'd0;
                end else begin
                    r.lo = sa / sb; r.hi = sa % sb;
                end
            end
            FUNC_DIVU: begin
                if (b == 32'd0) begin
                    r.lo = 32'hFFFF_FFFF; r.hi = a;
                end else begin
                    r.lo = a / b; r.hi = a % b;
                end
            end
            FUNC_MTHI: r.hi = a;
            FUNC_MTLO: r.lo = a;
            default: ;
        endcase
        return r;
    endfunction

    // Drives one op into both DUTs from mid-cycle and follows it to completion
    task automatic apply(input string name, input func_t f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo);
        exp_t        e;
        int          st1 = 0;
        int          st4 = 0;
        int          cyc = 0;
        bit          held = 1'b1;
        bit          done = 1'b0;
        bit          isdiv;
        logic [31:0] h1 = u_if1.hi_o;
        logic [31:0] l1 = u_if1.lo_o;
        logic [31:0] h4 = u_if4.hi_o;
        logic [31:0] l4 = u_if4.lo_o;
        isdiv = (f == FUNC_DIV) || (f == FUNC_DIVU);
        e.hi = ehi;
        e.lo = elo;
        sb_q.push_back(e);
        start = 1'b1; funct = f; rs = a; rt = b;
        while (!done) begin
            #1;
            if (u_if1.stall_o) st1++;
            if (u_if4.stall_o) st4++;
            if (cyc > 0 && u_if1.stall_o && (u_if1.hi_o !== h1 || u_if1.lo_o !== l1)) held = 1'b0;
            if (cyc > 0 && u_if4.stall_o && (u_if4.hi_o !== h4 || u_if4.lo_o !== l4)) held = 1'b0;
            if (cyc > 0 && !u_if1.stall_o && !u_if4.stall_o) begin
                done = 1'b1;
            end else if (cyc > 60) begin
                done = 1'b1;
                check({name, " timeout"}, 64'(cyc), 64'd0);
            end
            if (!done) begin
                @(posedge clk);
                #1;
                start = 1'b0;
                cyc++;
            end
        end
        start = 1'b0;
        e = sb_q.pop_front();
        check({name, " stall1"}, 64'(st1), isdiv ? 64'd34 : 64'd0);
        check({name, " stall4"}, 64'(st4), isdiv ? 64'd10 : 64'd0);
        check({name, " held"}, 64'(held), 64'd1);
        check({name, " hilo1"}, {u_if1.hi_o, u_if1.lo_o}, {e.hi, e.lo});
        check({name, " hilo4"}, {u_if4.hi_o, u_if4.lo_o}, {e.hi, e.lo});
    endtask

    initial begin
        vecs[0] = '{FUNC_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{FUNC_MULTU, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA};
        vecs[2] = '{FUNC_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{FUNC_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
        vecs[4] = '{FUNC_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        vecs[5] = '{FUNC_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
        vecs[6] = '{FUNC_ADD,   32'h1111_1111, 32'h2222_2222, 32'd5,         32'hFFFF_FFFF};
        vecs[7] = '{FUNC_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};

        rst_n = 1'b0; start = 1'b0; funct = FUNC_ADD; flush = 1'b0; rs = '0; rt = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("reset hilo1", {u_if1.hi_o, u_if1.lo_o}, 64'd0);
        check("reset hilo4", {u_if4.hi_o, u_if4.lo_o}, 64'd0);
        check("reset stall", {u_if1.stall_o, u_if4.stall_o}, 64'd0);
        m = '{32'd0, 32'd0};

        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
            m.hi = vecs[i].hi;
            m.lo = vecs[i].lo;
        end

        // Back-to-back MTHI / MTLO with no idle cycle between them
        @(posedge clk); #1;
        start = 1'b1; funct = FUNC_MTHI; rs = 32'h1234;
        #1 check("mthi stall", {u_if1.stall_o, u_if4.stall_o}, 64'd0);
        @(posedge clk); #1;
        funct = FUNC_MTLO; rs = 32'hABCD;
        #1 check("mtlo stall", {u_if1.stall_o, u_if4.stall_o}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        check("mthi/mtlo hilo1", {u_if1.hi_o, u_if1.lo_o}, {32'h1234, 32'hABCD});
        check("mthi/mtlo hilo4", {u_if4.hi_o, u_if4.lo_o}, {32'h1234, 32'hABCD});
        m = '{32'h1234, 32'hABCD};

        // Flush together with start in IDLE accepts nothing
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; funct = FUNC_DIV; rs = 32'd77; rt = 32'd3;
        #1 check("flush idle stall", {u_if1.stall_o, u_if4.stall_o}, 64'd0);
        @(posedge clk); #1;
        funct = FUNC_MULT;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        #1;
        check("flush idle stall after", {u_if1.stall_o, u_if4.stall_o}, 64'd0);
        check("flush idle hilo1", {u_if1.hi_o, u_if1.lo_o}, {m.hi, m.lo});
        check("flush idle hilo4", {u_if4.hi_o, u_if4.lo_o}, {m.hi, m.lo});

        // Flush on the tenth stall cycle, then an immediate new DIVU
        @(posedge clk); #1;
        start = 1'b1; funct = FUNC_DIV; rs = 32'd100; rt = 32'd3;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        flush = 1'b1;
        #1 check("pre-flush stall1", 64'(u_if1.stall_o), 64'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        check("flush stall", {u_if1.stall_o, u_if4.stall_o}, 64'd0);
        check("flush hilo1", {u_if1.hi_o, u_if1.lo_o}, {m.hi, m.lo});
        check("flush hilo4", {u_if4.hi_o, u_if4.lo_o}, {m.hi, m.lo});
        apply("divu after flush", FUNC_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        m = '{32'd2, 32'd14};

        for (int i = 0; i < 6; i++) begin
            func_t       f;
            logic [31:0] a;
            logic [31:0] b;
            exp_t        e;
            case ($urandom_range(0, 3))
                0:       f = FUNC_MULT;
                1:       f = FUNC_MULTU;
                2:       f = FUNC_DIV;
                default: f = FUNC_DIVU;
            endcase
            a = $urandom;
            b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 255));
            e = model(f, a, b, m);
            apply($sformatf("rand%0d", i), f, a, b, e.hi, e.lo);
            m = e;
        end

        // Reset for one edge while a divide is in flight
        @(posedge clk); #1;
        start = 1'b1; funct = FUNC_DIV; rs = 32'hFFFF_FFF9; rt = 32'd2;
        repeat (5) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("mid-div reset hilo1", {u_if1.hi_o, u_if1.lo_o}, 64'd0);
        check("mid-div reset hilo4", {u_if4.hi_o, u_if4.lo_o}, 64'd0);
        check("mid-div reset stall", {u_if1.stall_o, u_if4.stall_o}, 64'd0);
        @(posedge clk); #1;
        check("post-reset stall", {u_if1.stall_o, u_if4.stall_o}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
